// File: rtl/i2c_frame_sender.sv
// ---------------------------------------------------------------------------
// i2c_frame_sender
//   Serialises one 24-bit codec configuration word as a single I2C write
//   frame (WM8731 control bus): START, three bytes MSB-first, an ACK slot
//   after each byte, STOP.
//
//   Timing is built from a quarter-period tick Q = CLK_DIV clock cycles.
//   Frame = START (2Q) + 27 bit slots (4Q each) + STOP (4Q) = 114Q.
//
// Parameters
//   CLK_DIV     clock cycles per SCL quarter period (>= 2)
//
// Ports
//   i_clk       system clock, all state on posedge
//   i_rst_n     asynchronous active-low reset
//   i_start     frame request, accepted only while idle
//   i_data      24-bit payload, bits [23:16] sent first
//   o_finished  1 = idle/ready, 0 = frame in progress
//   o_nack      sticky NACK flag (tied 0 unless ACK_CHECK_EN)
//   o_sclk      SCL, push-pull
//   o_sdat      SDA, open-drain (drives 0 or z)
//
// Optional feature (macro ACK_CHECK_EN)
//   When defined, SDA is sampled at the last cycle of Q2 in every ACK slot.
//   A high sample sets o_nack and the frame jumps to STOP after that slot.
// ---------------------------------------------------------------------------
module i2c_frame_sender #(
  parameter int CLK_DIV = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [23:0] i_data,
  output logic        o_finished,
  output logic        o_nack,
  output logic        o_sclk,
  inout  wire         o_sdat
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] LAST_SLOT = 5'd26;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_q;
  logic [4:0]       r_slot;
  logic [23:0]      r_shift;
  logic             r_nack;
  logic             r_sclk;
  logic             r_sda_low;

  state_t           w_state_next;
  logic [DIV_W-1:0] w_div_next;
  logic [1:0]       w_q_next;
  logic [4:0]       w_slot_next;
  logic [23:0]      w_shift_next;
  logic             w_nack_next;
  logic             w_sclk_next;
  logic             w_sda_low_next;
  logic             w_tick;
  logic             w_ack_slot;
  logic             w_ack_slot_next;

  function automatic logic is_ack_slot(input logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

  assign w_tick          = (r_div == DIV_LAST);
  assign w_ack_slot      = is_ack_slot(r_slot);
  assign w_ack_slot_next = is_ack_slot(w_slot_next);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_q       <= '0;
      r_slot    <= '0;
      r_shift   <= '0;
      r_nack    <= 1'b0;
      r_sclk    <= 1'b1;
      r_sda_low <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_q       <= w_q_next;
      r_slot    <= w_slot_next;
      r_shift   <= w_shift_next;
      r_nack    <= w_nack_next;
      r_sclk    <= w_sclk_next;
      r_sda_low <= w_sda_low_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_q_next       = r_q;
    w_slot_next    = r_slot;
    w_shift_next   = r_shift;
    w_nack_next    = r_nack;
    w_sclk_next    = 1'b1;
    w_sda_low_next = 1'b0;
    // The divider only runs while a frame is in flight, so each frame
    // starts on a clean quarter boundary.
    w_div_next     = (r_state == S_IDLE || w_tick) ? '0 : r_div + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_START;
          w_shift_next = i_data;
          w_q_next     = 2'd0;
          w_slot_next  = 5'd0;
          w_nack_next  = 1'b0;
        end
      end

      S_START: begin
        if (w_tick) begin
          if (r_q == 2'd1) begin
            w_state_next = S_BIT;
            w_q_next     = 2'd0;
            w_slot_next  = 5'd0;
          end else begin
            w_q_next = r_q + 2'd1;
          end
        end
      end

      S_BIT: begin
`ifdef ACK_CHECK_EN
        // Sample on the last cycle of Q2, well inside the SCL high phase.
        if (w_ack_slot && r_q == 2'd2 && w_tick && o_sdat == 1'b1) begin
          w_nack_next = 1'b1;
        end
`endif
        if (w_tick) begin
          if (r_q == 2'd3) begin
            w_q_next = 2'd0;
            // r_nack can only be set within the current frame, so it marks
            // the slot just finished as NACKed.
            if (r_slot == LAST_SLOT || r_nack) begin
              w_state_next = S_STOP;
            end else begin
              w_slot_next = r_slot + 5'd1;
              if (!w_ack_slot) begin
                w_shift_next = {r_shift[22:0], 1'b0};
              end
            end
          end else begin
            w_q_next = r_q + 2'd1;
          end
        end
      end

      S_STOP: begin
        if (w_tick) begin
          if (r_q == 2'd3) begin
            w_state_next = S_IDLE;
            w_q_next     = 2'd0;
            w_slot_next  = 5'd0;
          end else begin
            w_q_next = r_q + 2'd1;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    // Bus levels are decoded from the next state and registered, so the
    // pins line up with the state register and are glitch-free.
    case (w_state_next)
      S_IDLE: begin
        w_sclk_next    = 1'b1;
        w_sda_low_next = 1'b0;
      end
      S_START: begin
        w_sclk_next    = 1'b1;
        w_sda_low_next = 1'b1;
      end
      S_BIT: begin
        w_sclk_next    = w_q_next[1];
        w_sda_low_next = w_ack_slot_next ? 1'b0 : ~w_shift_next[23];
      end
      S_STOP: begin
        w_sclk_next    = (w_q_next != 2'd0);
        w_sda_low_next = ~w_q_next[1];
      end
      default: begin
        w_sclk_next    = 1'b1;
        w_sda_low_next = 1'b0;
      end
    endcase
  end

  assign o_finished = (r_state == S_IDLE);
  assign o_sclk     = r_sclk;
  assign o_sdat     = r_sda_low ? 1'b0 : 1'bz;

`ifdef ACK_CHECK_EN
  assign o_nack = r_nack;
`else
  assign o_nack = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_frame_sender.sv
module tb_i2c_frame_sender;

  localparam int CLK_DIV = 4;
  localparam int FRAME_CYC = 114 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [23:0] i_data;
  logic        o_finished;
  logic        o_nack;
  logic        o_sclk;
  wire         sda;
  logic        slave_low;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_frame_sender #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_data     (i_data),
    .o_finished (o_finished),
    .o_nack     (o_nack),
    .o_sclk     (o_sclk),
    .o_sdat     (sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave / bus monitor ----------------
  int          slave_nack_byte = -1;
  logic [23:0] rx_word_q[$];
  int          rx_cnt_q[$];
  int          scl_falls = 0;
  logic [23:0] rx_word;
  logic [7:0]  rx_sh;
  int          rx_cnt;
  int          bc;
  bit          in_frame;

  initial begin
    logic prev_scl, prev_sda, cur_scl, cur_sda;
    prev_scl = 1'b1; prev_sda = 1'b1;
    slave_low = 1'b0; bc = 0; rx_cnt = 0; rx_word = '0; rx_sh = '0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      cur_scl = o_sclk;
      cur_sda = (sda === 1'b0) ? 1'b0 : 1'b1;
      if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        bc = 0; rx_cnt = 0; rx_word = '0; slave_low = 1'b0; in_frame = 1'b1;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        if (in_frame) begin
          rx_word_q.push_back(rx_word);
          rx_cnt_q.push_back(rx_cnt);
        end
        in_frame = 1'b0; slave_low = 1'b0;
      end else if (!prev_scl && cur_scl) begin
        if (bc == 8) begin
          bc = 0;
        end else begin
          rx_sh = {rx_sh[6:0], cur_sda};
          bc++;
          if (bc == 8) begin
            rx_word = {rx_word[15:0], rx_sh};
            rx_cnt++;
          end
        end
      end else if (prev_scl && !cur_scl) begin
        scl_falls++;
        if (slave_low) slave_low = 1'b0;
        else if (bc == 8 && in_frame) slave_low = ((rx_cnt - 1) != slave_nack_byte);
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_bytes(input int nack_b);
    return (ACK_EN && nack_b >= 0) ? nack_b + 1 : 3;
  endfunction

  function automatic int model_len(input int nack_b);
    int k;
    if (ACK_EN && nack_b >= 0) begin
      k = 8 + 9 * nack_b;
      return (2 + 4 * (k + 1) + 4) * CLK_DIV;
    end
    return FRAME_CYC;
  endfunction

  task automatic check_frame(input string tag, input logic [23:0] d, input int nack_b);
    int nb;
    logic [23:0] w;
    logic [23:0] exp_w;
    nb = model_bytes(nack_b);
    exp_w = d >> (8 * (3 - nb));
    if (rx_cnt_q.size() == 0) begin
      check_val({tag, "_seen"}, 0, 1);
    end else begin
      w = rx_word_q.pop_front();
      check_val({tag, "_nbytes"}, rx_cnt_q.pop_front(), nb);
      check_val({tag, "_data"}, w, exp_w);
    end
  endtask

  // Count negedges with o_finished low, starting at the current one.
  task automatic count_low(input bit junk, output int n);
    n = 0;
    while (o_finished == 1'b0 && n < 2000) begin
      if (junk && n == 100) begin i_data = 24'hFFFFFF; i_start = 1'b1; end
      if (junk && n == 101) i_start = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [23:0] d, input int nack_b, input bit junk);
    int n;
    slave_nack_byte = nack_b;
    @(negedge clk);
    i_data = d; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_val({tag, "_fin_fall"}, o_finished, 0);
    check_val({tag, "_nack_clr"}, o_nack, 0);
    if (!junk) i_data = 24'($urandom);
    count_low(junk, n);
    check_val({tag, "_len"}, n, model_len(nack_b));
    check_frame(tag, d, nack_b);
    check_val({tag, "_nack"}, o_nack, (ACK_EN && nack_b >= 0) ? 1 : 0);
    @(negedge clk);
    check_val({tag, "_stay_idle"}, o_finished, 1);
    $display("frame %s data=%06h nack_byte=%0d len=%0d", tag, d, nack_b, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, h, falls0, gap, nb;
    logic [23:0] a, b, d;
    rst_n = 1'b0; i_start = 1'b0; i_data = '0;

    // 1. reset values and quiet bus after release
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_sclk", o_sclk, 1);
    check_val("rst_sda", (sda === 1'b0) ? 0 : 1, 1);
    check_val("rst_fin", o_finished, 1);
    check_val("rst_nack", o_nack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    falls0 = scl_falls;
    repeat (20) @(negedge clk);
    check_val("idle_sclk", o_sclk, 1);
    check_val("idle_fin", o_finished, 1);
    check_val("idle_no_edges", scl_falls - falls0, 0);
    $display("reset/idle checks done");

    // 2. basic frame
    run_frame("basic", 24'h341E00, -1, 1'b0);

    // 3. ignored mid-frame start with all-ones data
    run_frame("junk", 24'h341E00, -1, 1'b1);

    // 4. i_start held across two frames
    a = 24'h340815; b = 24'h340C00;
    slave_nack_byte = -1;
    @(negedge clk);
    i_data = a; i_start = 1'b1;
    @(negedge clk);
    check_val("hold_fin_fall", o_finished, 0);
    i_data = b;
    count_low(1'b0, n1);
    check_val("hold_len1", n1, FRAME_CYC);
    h = 0;
    while (o_finished == 1'b1 && h < 10) begin h++; @(negedge clk); end
    check_val("hold_idle_gap", h, 1);
    i_start = 1'b0; i_data = 24'($urandom);
    count_low(1'b0, n2);
    check_val("hold_len2", n2, FRAME_CYC);
    check_frame("hold_f1", a, -1);
    check_frame("hold_f2", b, -1);
    $display("hold frames %06h %06h len=%0d/%0d gap=%0d", a, b, n1, n2, h);

`ifdef ACK_CHECK_EN
    // 5. NACK on slot 17, then a clean frame clears the flag
    run_frame("nack17", 24'h341E00, 1, 1'b0);
    run_frame("after_nack", 24'h340A12, -1, 1'b0);
`endif

    // randomized frames
    for (int i = 0; i < 8; i++) begin
      d = 24'($urandom);
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
      if (!ACK_EN) nb = -1;
      run_frame($sformatf("rnd%0d", i), d, nb, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
    end

    // 6. reset during byte 2, then a fresh frame
    slave_nack_byte = -1;
    @(negedge clk);
    i_data = 24'($urandom); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (160 + $urandom_range(0, 90)) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sclk", o_sclk, 1);
    check_val("mid_rst_sda", (sda === 1'b0) ? 0 : 1, 1);
    check_val("mid_rst_fin", o_finished, 1);
    check_val("mid_rst_nack", o_nack, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rx_word_q.delete();
    rx_cnt_q.delete();
    $display("mid-frame reset checks done");
    run_frame("post_rst", 24'h341201, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
